intr_ctrl: RTL
==============

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NSRC, default 8: number of external interrupt sources (1..31).
REQ-002 Parameter CAUSE_BASE, default 16: cause code reported for source 0.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 irq_src_i  in  NSRC  level inputs from peripherals; rising edge requests an interrupt.
REQ-006 wr_en_i  in  1  register write strobe.
REQ-007 addr_i  in  4  register byte address (0x0, 0x4, 0x8, 0xC).
REQ-008 wdata_i  in  32  register write data.
REQ-009 rdata_o  out  32  register read data, combinational from addr_i.
REQ-010 int_read_i  in  1  one-cycle claim pulse from the CSR unit.
REQ-011 m_ext_intr_o  out  1  machine external interrupt request to the CSR unit.
REQ-012 mcause_o  out  31  cause code of the presented source, stable while m_ext_intr_o is high.

Function
REQ-013 Edge detect: pending[i] SHALL set on the edge where the sampled source is 1 and its previous sample is 0.
REQ-014 Registers: 0x0 ENABLE (RW, bits [NSRC-1:0]); 0x4 PENDING (RO); 0x8 CLAIMED (RO, {27'b0, id}); 0xC COMPLETE (WO, wdata_i[4:0] = id); other addresses read 0, writes ignored.
REQ-015 FSM states IDLE, PRESENT, SERVICE; reset state IDLE.
REQ-016 IDLE->PRESENT on the edge where (pending & enable) != 0; id captured = lowest set index.
REQ-017 m_ext_intr_o SHALL be 1 exactly in PRESENT; mcause_o = CAUSE_BASE + id, held in a register.
REQ-018 PRESENT->SERVICE on int_read_i=1; pending[id] cleared on the same edge.
REQ-019 PRESENT->IDLE if enable[id] is cleared before a claim; int_read_i in the same cycle wins (SERVICE).
REQ-020 SERVICE->IDLE on a COMPLETE write whose id equals the claimed id; mismatched id ignored.
REQ-021 int_read_i in IDLE or SERVICE SHALL be ignored.
REQ-022 New edge on the claimed source in the same cycle as its clear: set wins, pending stays 1.
REQ-023 Sources of any index continue latching pending while in PRESENT or SERVICE; no preemption.
REQ-024 Index width: id is 5 bits; CAUSE_BASE + id computed in 31 bits without wrap.

Reset
REQ-025 rst_ni low SHALL immediately force: state IDLE, pending 0, enable 0, claimed id 0, edge/sync history 0, m_ext_intr_o 0, mcause_o 0.
REQ-026 Reset during PRESENT or SERVICE SHALL drop m_ext_intr_o in the same cycle, with no pending retained.
REQ-027 First rising edge after rst_ni deasserts SHALL not detect an edge on sources already high at reset release.

Configuration
REQ-028 Macro INTR_CTRL_SYNC_EN defined: each irq_src_i passes a 2-flop synchronizer before edge detect; pending sets on the 3rd rising edge after the source rises.
REQ-029 Macro undefined: irq_src_i sampled directly (sources assumed synchronous to clk_i); pending sets on the 1st rising edge sampling 1.

Verification
REQ-030 ENABLE=0x01, pulse src0 -> PENDING=0x01, m_ext_intr_o=1, mcause_o=16 next cycle; int_read_i pulse -> PENDING=0, CLAIMED=0; COMPLETE=0 -> IDLE.
REQ-031 ENABLE=0xFF, src5 and src2 rise same cycle -> mcause_o=18; after complete, re-present with mcause_o=21.
REQ-032 In PRESENT (id 3), clear ENABLE bit3 -> m_ext_intr_o=0 next cycle, PENDING bit3 stays 1; ENABLE=0x08 again -> re-presents mcause_o=19.
REQ-033 In SERVICE (id 1), COMPLETE=4 -> remains SERVICE; COMPLETE=1 -> IDLE; int_read_i in SERVICE has no effect.
REQ-034 src0 rises in the claim cycle of id 0 -> PENDING bit0=1 after claim, re-presented after complete.
REQ-035 Assert rst_ni=0 mid-PRESENT asynchronously -> m_ext_intr_o=0, mcause_o=0, PENDING=0 before next clock edge; latency check with and without INTR_CTRL_SYNC_EN (3 vs 1 edges).

Source files
------------

// File: rtl/intr_ctrl.sv
// Machine external interrupt controller: edge-latched pending sources, lowest-index
// priority, claim/complete handshake. Define INTR_CTRL_SYNC_EN to add 2-flop input synchronizers.
module intr_ctrl #(
  parameter int unsigned NSRC       = 8,
  parameter int unsigned CAUSE_BASE = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NSRC-1:0] irq_src_i,
  input  logic            wr_en_i,
  input  logic [3:0]      addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  input  logic            int_read_i,
  output logic            m_ext_intr_o,
  output logic [30:0]     mcause_o
);

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] sampled, prev_q, rise;
  logic            armed_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] active, id_mask, clr_mask;
  logic [4:0]      id_q, id_d, low_id;
  logic [30:0]     cause_d;
  logic            claim, complete;
  logic            unused_wdata;

  assign unused_wdata = ^wdata_i;

`ifdef INTR_CTRL_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = irq_src_i;
`endif

  // armed_q masks the first edge after reset so sources already high are not latched.
  assign rise = armed_q ? (sampled & ~prev_q) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q <= 1'b0;
      prev_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      prev_q  <= sampled;
    end
  end

  assign enable_d = (wr_en_i && addr_i == 4'h0) ? wdata_i[NSRC-1:0] : enable_q;
  assign complete = wr_en_i && (addr_i == 4'hC) && (wdata_i[4:0] == id_q);
  assign active   = pending_q & enable_q;
  assign id_mask  = {{(NSRC-1){1'b0}}, 1'b1} << id_q;
  assign clr_mask = claim ? id_mask : '0;

  // Set wins over a same-cycle claim clear.
  assign pending_d = (pending_q & ~clr_mask) | rise;

  always_comb begin
    low_id = '0;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (active[i-1]) low_id = 5'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cause_d = mcause_o;
    claim   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = PRESENT;
          id_d    = low_id;
          cause_d = 31'(CAUSE_BASE) + 31'(low_id);
        end
      end
      PRESENT: begin
        if (int_read_i) begin
          state_d = SERVICE;
          claim   = 1'b1;
        end else if ((enable_d & id_mask) == '0) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      enable_q  <= '0;
      id_q      <= '0;
      mcause_o  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      id_q      <= id_d;
      mcause_o  <= cause_d;
    end
  end

  assign m_ext_intr_o = (state_q == PRESENT);

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      4'h0:    rdata_o[NSRC-1:0] = enable_q;
      4'h4:    rdata_o[NSRC-1:0] = pending_q;
      4'h8:    rdata_o[4:0]      = id_q;
      default: rdata_o = '0;
    endcase
  end

endmodule
